// File: rtl/mul_hilo_ctrl.sv
// mul_hilo_ctrl: sequencing controller for an iterative 32x32 signed multiplier with HI/LO result registers.
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   start             multiply request, only sampled in IDLE
//   op_a, op_b        signed operands, captured together with an accepted start
//   mul_x, mul_y      registered operands driven to the downstream multiplier
//   mul_load          one-cycle pulse telling the multiplier to clear and restart
//   mul_z             signed 64-bit product returned by the multiplier
//   bus_in            data for direct HI/LO writes
//   hi_wr, lo_wr      direct-write strobes for HI and LO
//   hi_out, lo_out    registered HI and LO values
//   busy              high while a multiply is in progress
//   done              one-cycle pulse marking that HI/LO hold a new product
//
// Optional feature: define MUL_ZERO_SKIP_EN to short-circuit multiplies with a
// zero operand straight to the capture state, writing a zero product.
module mul_hilo_ctrl #(
   parameter int ITERS = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic [31:0] mul_x,
   output logic [31:0] mul_y,
   output logic        mul_load,
   input  logic [63:0] mul_z,
   input  logic [31:0] bus_in,
   input  logic        hi_wr,
   input  logic        lo_wr,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out,
   output logic        busy,
   output logic        done
);
   typedef enum logic [1:0] {IDLE, LOAD, RUN, CAPT} state_t;
   localparam logic [5:0] LAST = 6'(ITERS - 1);
   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] x_q, x_d, y_q, y_d, hi_q, hi_d, lo_q, lo_d;
   logic        done_q, done_d, zero_q, zero_d, zero_op;
`ifdef MUL_ZERO_SKIP_EN
   assign zero_op = (op_a == 32'd0) || (op_b == 32'd0);
`else
   assign zero_op = 1'b0;
`endif
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      x_d     = x_q;
      y_d     = y_q;
      zero_d  = zero_q;
      done_d  = 1'b0;
      hi_d    = hi_wr ? bus_in : hi_q;
      lo_d    = lo_wr ? bus_in : lo_q;
      case (state_q)
         IDLE: if (start) begin
            x_d     = op_a;
            y_d     = op_b;
            zero_d  = zero_op;
            state_d = zero_op ? CAPT : LOAD;
         end
         LOAD: begin
            cnt_d   = 6'd0;
            state_d = RUN;
         end
         RUN: begin
            cnt_d   = cnt_q + 6'd1;
            state_d = (cnt_q == LAST) ? CAPT : RUN;
         end
         // capture is assigned after the direct writes so it wins a collision
         CAPT: begin
            hi_d    = zero_q ? 32'd0 : mul_z[63:32];
            lo_d    = zero_q ? 32'd0 : mul_z[31:0];
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 6'd0;
         x_q     <= 32'd0;
         y_q     <= 32'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         done_q  <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         x_q     <= x_d;
         y_q     <= y_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
         zero_q  <= zero_d;
      end
   end
   assign mul_x    = x_q;
   assign mul_y    = y_q;
   assign hi_out   = hi_q;
   assign lo_out   = lo_q;
   assign done     = done_q;
   assign mul_load = (state_q == LOAD);
   assign busy     = (state_q != IDLE);
endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// tb_mul_hilo_ctrl: directed self-checking bench for mul_hilo_ctrl with a behavioural multiplier on mul_z.
module tb_mul_hilo_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] op_a = 32'd0, op_b = 32'd0, bus_in = 32'd0;
   logic        hi_wr = 1'b0, lo_wr = 1'b0;
   logic [31:0] mul_x, mul_y, hi_out, lo_out;
   logic [63:0] mul_z;
   logic        mul_load, busy, done;
   int          pass = 0, total = 0;

   mul_hilo_ctrl #(.ITERS(32)) dut (
      .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
      .mul_x(mul_x), .mul_y(mul_y), .mul_load(mul_load), .mul_z(mul_z),
      .bus_in(bus_in), .hi_wr(hi_wr), .lo_wr(lo_wr),
      .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   assign mul_z = $signed(mul_x) * $signed(mul_y);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // waits from a busy sample until the first idle sample, counting busy cycles, loads and dones
   task automatic wait_idle(output int bc, output int ld, output int dn);
      bc = 0; ld = 0; dn = 0;
      for (int i = 0; i < 200; i++) begin
         if (mul_load) ld++;
         if (done) dn++;
         if (!busy) break;
         bc++;
         step();
      end
   endtask

   task automatic launch(input logic [31:0] a, input logic [31:0] b);
      op_a = a; op_b = b; start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      total++; if (busy !== 1'b0 || done !== 1'b0 || mul_load !== 1'b0) $display("FAIL reset_ctl got busy=%b done=%b load=%b exp 000", busy, done, mul_load); else pass++;
      total++; if (hi_out !== 32'd0 || lo_out !== 32'd0) $display("FAIL reset_hilo got %h/%h exp 0/0", hi_out, lo_out); else pass++;
      total++; if (mul_x !== 32'd0 || mul_y !== 32'd0) $display("FAIL reset_xy got %h/%h exp 0/0", mul_x, mul_y); else pass++;
      step(); step();
      rst = 1'b0;
   endtask

   task automatic test_multiply();
      int bc, ld, dn;
      launch(32'd7, -32'sd3);
      total++; if (mul_x !== 32'd7 || mul_y !== 32'hFFFFFFFD) $display("FAIL mul_operands got %h/%h exp 00000007/fffffffd", mul_x, mul_y); else pass++;
      wait_idle(bc, ld, dn);
      total++; if (bc !== 34) $display("FAIL mul_busy_cycles got %0d exp 34", bc); else pass++;
      total++; if (ld !== 1) $display("FAIL mul_load_pulses got %0d exp 1", ld); else pass++;
      total++; if (dn !== 1) $display("FAIL mul_done got %0d exp 1", dn); else pass++;
      total++; if (hi_out !== 32'hFFFFFFFF || lo_out !== 32'hFFFFFFEB) $display("FAIL mul_result got %h/%h exp ffffffff/ffffffeb", hi_out, lo_out); else pass++;
      step();
      total++; if (done !== 1'b0) $display("FAIL mul_done_width got %b exp 0", done); else pass++;
   endtask

   task automatic test_overlap();
      int bc, ld, dn, extra;
      launch(32'd5, 32'd6);
      repeat (10) step();
      op_a = 32'd99; op_b = 32'd99; start = 1'b1;
      step();
      start = 1'b0;
      wait_idle(bc, ld, dn);
      extra = 0;
      repeat (3) begin step(); if (done) extra++; end
      total++; if (dn + extra !== 1) $display("FAIL ovl_done_pulses got %0d exp 1", dn + extra); else pass++;
      total++; if (mul_x !== 32'd5 || mul_y !== 32'd6) $display("FAIL ovl_operands got %h/%h exp 5/6", mul_x, mul_y); else pass++;
      total++; if (hi_out !== 32'd0 || lo_out !== 32'd30) $display("FAIL ovl_result got %h/%h exp 0/1e", hi_out, lo_out); else pass++;
      total++; if (busy !== 1'b0) $display("FAIL ovl_idle got %b exp 0", busy); else pass++;
   endtask

   task automatic test_back_to_back();
      int bc, ld, dn;
      op_a = 32'd3; op_b = 32'd4; start = 1'b1;
      step();
      wait_idle(bc, ld, dn);
      total++; if (done !== 1'b1 || hi_out !== 32'd0 || lo_out !== 32'd12) $display("FAIL b2b_first got done=%b %h/%h exp 1 0/c", done, hi_out, lo_out); else pass++;
      op_a = 32'h80000000; op_b = 32'h80000000;
      step();
      start = 1'b0;
      total++; if (busy !== 1'b1 || mul_load !== 1'b1 || mul_x !== 32'h80000000) $display("FAIL b2b_accept got busy=%b load=%b x=%h exp 1 1 80000000", busy, mul_load, mul_x); else pass++;
      wait_idle(bc, ld, dn);
      total++; if (bc !== 34 || dn !== 1) $display("FAIL b2b_second_seq got busy=%0d done=%0d exp 34 1", bc, dn); else pass++;
      total++; if (hi_out !== 32'h40000000 || lo_out !== 32'd0) $display("FAIL b2b_result got %h/%h exp 40000000/0", hi_out, lo_out); else pass++;
   endtask

   task automatic test_write_collision();
      launch(32'd2, 32'd3);
      repeat (33) step();
      total++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL col_in_capt got busy=%b done=%b exp 1 0", busy, done); else pass++;
      bus_in = 32'h12345678; hi_wr = 1'b1; lo_wr = 1'b1;
      step();
      hi_wr = 1'b0; lo_wr = 1'b0;
      total++; if (done !== 1'b1 || hi_out !== 32'd0 || lo_out !== 32'd6) $display("FAIL col_capture_wins got done=%b %h/%h exp 1 0/6", done, hi_out, lo_out); else pass++;
      hi_wr = 1'b1;
      step();
      hi_wr = 1'b0;
      total++; if (hi_out !== 32'h12345678 || lo_out !== 32'd6) $display("FAIL col_hi_write got %h/%h exp 12345678/6", hi_out, lo_out); else pass++;
      bus_in = 32'hCAFEF00D; lo_wr = 1'b1;
      step();
      lo_wr = 1'b0;
      total++; if (hi_out !== 32'h12345678 || lo_out !== 32'hCAFEF00D) $display("FAIL col_lo_write got %h/%h exp 12345678/cafef00d", hi_out, lo_out); else pass++;
      step();
      total++; if (hi_out !== 32'h12345678 || lo_out !== 32'hCAFEF00D) $display("FAIL col_hold got %h/%h exp 12345678/cafef00d", hi_out, lo_out); else pass++;
   endtask

   task automatic test_reset_mid_run();
      int bc, ld, dn, seen;
      launch(32'd7, -32'sd3);
      repeat (16) step();
      rst = 1'b1;
      #1;
      total++; if (busy !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd0 || done !== 1'b0) $display("FAIL rst_abort got busy=%b done=%b %h/%h exp 0 0 0/0", busy, done, hi_out, lo_out); else pass++;
      seen = 0;
      repeat (2) begin step(); if (done) seen++; end
      total++; if (seen !== 0 || mul_x !== 32'd0) $display("FAIL rst_hold got dones=%0d x=%h exp 0 0", seen, mul_x); else pass++;
      rst = 1'b0;
      launch(32'd9, 32'd9);
      total++; if (busy !== 1'b1 || mul_load !== 1'b1) $display("FAIL rst_restart got busy=%b load=%b exp 1 1", busy, mul_load); else pass++;
      wait_idle(bc, ld, dn);
      total++; if (bc !== 34 || dn !== 1 || hi_out !== 32'd0 || lo_out !== 32'd81) $display("FAIL rst_complete got busy=%0d done=%0d %h/%h exp 34 1 0/51", bc, dn, hi_out, lo_out); else pass++;
   endtask

   task automatic test_zero_operand();
      int bc, ld, dn;
      bus_in = 32'h5A5A5A5A; hi_wr = 1'b1; lo_wr = 1'b1;
      step();
      hi_wr = 1'b0; lo_wr = 1'b0;
      launch(32'd5, 32'd0);
`ifdef MUL_ZERO_SKIP_EN
      total++; if (busy !== 1'b1 || mul_load !== 1'b0) $display("FAIL zero_skip_capt got busy=%b load=%b exp 1 0", busy, mul_load); else pass++;
      step();
      total++; if (done !== 1'b1 || busy !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd0) $display("FAIL zero_skip_done got done=%b busy=%b %h/%h exp 1 0 0/0", done, busy, hi_out, lo_out); else pass++;
`else
      wait_idle(bc, ld, dn);
      total++; if (bc !== 34 || ld !== 1) $display("FAIL zero_full_seq got busy=%0d loads=%0d exp 34 1", bc, ld); else pass++;
      total++; if (dn !== 1 || hi_out !== 32'd0 || lo_out !== 32'd0) $display("FAIL zero_full_result got done=%0d %h/%h exp 1 0/0", dn, hi_out, lo_out); else pass++;
`endif
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_multiply();
      test_overlap();
      test_back_to_back();
      test_write_collision();
      test_reset_mid_run();
      test_zero_operand();
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule

// File: doc/mul_hilo_ctrl.md
MUL_HILO_CTRL -- requirements
Module: mul_hilo_ctrl

Interface
REQ-001 The block SHALL have parameter ITERS, default 32, giving the number of multiplier iteration cycles (legal range 2..63).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL change on the rising edge of clk.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, a request to begin a multiply, sampled in IDLE only.
REQ-005 The block SHALL have ports op_a and op_b, input, 32 each, signed multiplicand and multiplier, sampled with start.
REQ-006 The block SHALL have ports mul_x and mul_y, output, 32 each, registered operands driven to the downstream iterative multiplier.
REQ-007 The block SHALL have port mul_load, output, 1, a one-cycle pulse telling the multiplier to clear and restart.
REQ-008 The block SHALL have port mul_z, input, 64, the signed product returned by the multiplier.
REQ-009 The block SHALL have port bus_in, input, 32, the data for direct HI/LO writes.
REQ-010 The block SHALL have ports hi_wr and lo_wr, input, 1 each, direct-write strobes for HI and LO.
REQ-011 The block SHALL have ports hi_out and lo_out, output, 32 each, the registered HI and LO values.
REQ-012 The block SHALL have port busy, output, 1, high while a multiply is in progress.
REQ-013 The block SHALL have port done, output, 1, a one-cycle pulse marking that HI/LO hold a new product.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, RUN and CAPT, and only these.
REQ-015 In IDLE with start=1, the block SHALL at the next edge latch op_a into mul_x and op_b into mul_y, and enter LOAD.
REQ-016 mul_load SHALL be 1 only while the FSM is in LOAD (exactly one cycle); LOAD SHALL always go to RUN with the counter cleared to 0.
REQ-017 In RUN, the 6-bit counter SHALL increment once per cycle, and RUN SHALL go to CAPT on the edge where the counter equals ITERS-1 (RUN lasts exactly ITERS cycles).
REQ-018 On the edge that leaves CAPT, the block SHALL load hi_out with mul_z[63:32] and lo_out with mul_z[31:0], return to IDLE, and drive done=1 for that one following cycle.
REQ-019 busy SHALL be 1 in LOAD, RUN and CAPT, and 0 in IDLE.
REQ-020 Latency SHALL be ITERS+3 rising edges from the edge that samples start up to and including the edge that updates hi_out and lo_out (35 edges for ITERS=32).
REQ-021 A start asserted while busy=1 SHALL be ignored, and mul_x and mul_y SHALL hold their values.
REQ-022 A start in the IDLE cycle where done=1 SHALL be accepted (back-to-back operation).
REQ-023 When hi_wr=1 at an edge, hi_out SHALL take bus_in; when lo_wr=1 at an edge, lo_out SHALL take bus_in; this SHALL apply in any state.
REQ-024 If a direct write and the CAPT capture fall on the same edge, the product capture SHALL win for both HI and LO.
REQ-025 hi_out and lo_out SHALL otherwise hold their values; mul_x and mul_y SHALL hold from load until the next accepted start.

Reset
REQ-026 While rst=1, the FSM SHALL be IDLE and the counter 0.
REQ-027 While rst=1, mul_x, mul_y, hi_out and lo_out SHALL be 0, and mul_load, busy and done SHALL be 0.
REQ-028 rst asserted mid-operation SHALL abort the multiply immediately with no capture, and IDLE SHALL accept a start on the first edge after release.

Configuration
REQ-029 With macro MUL_ZERO_SKIP_EN defined, a start with op_a==0 or op_b==0 SHALL go IDLE->CAPT directly, skipping LOAD and RUN with no mul_load pulse.
REQ-030 In that zero-skip case, hi_out and lo_out SHALL be written 0 (ignoring mul_z) and done SHALL pulse, with latency 2 edges from the sampling edge.
REQ-031 With MUL_ZERO_SKIP_EN undefined, zero operands SHALL take the full sequence of REQ-015..REQ-020.

Verification
REQ-032 Multiply 7 x -3: op_a=7, op_b=-3, start pulse, bench model drives mul_z -> mul_load seen once, busy for 34 cycles, then done with hi_out=FFFFFFFF and lo_out=FFFFFFEB.
REQ-033 Overlapped start: start again at cycle 10 of a busy run -> ignored, single done pulse, mul_x and mul_y unchanged.
REQ-034 Back-to-back: start held high through done, second multiply 0x80000000 x 0x80000000 -> hi_out=40000000 and lo_out=00000000 after the second done.
REQ-035 Write collision: hi_wr=1 with bus_in=12345678 on the capture edge -> hi_out equals the product, not 12345678; hi_wr in IDLE -> hi_out=12345678 next cycle.
REQ-036 Reset mid-run: rst at RUN count 15 -> busy=0, hi_out=0, lo_out=0 and no done pulse; a new start after release completes normally.
REQ-037 Zero operand: op_b=0, run once with the macro defined -> done 2 edges after start and no mul_load; run again without the macro -> done after the full 35 edges.
